// File: rtl/cpu_pkg.sv
// Shared definitions for the load/store path: access-size codes and the
// MEM-stage controller state encoding.
package cpu_pkg;

  // Func3 access-type codes for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/mem_access_check.sv
// Combinational legality, alignment and range decode for one memory access.
// Shared with the IF stage, so it knows nothing about request handshakes.
module mem_access_check
  import cpu_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic        i_is_store,
  input  logic [2:0]  i_func3,
  input  logic [31:0] i_addr,
  output logic        o_illegal,
  output logic        o_misaligned,
  output logic        o_out_of_range
);

  // One past the last valid byte address; 33 bits so a full 4 GiB map fits.
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  // Decode Func3 into legality and the alignment rule for that size
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and infers a latch.
    o_illegal    = 1'b0;
    o_misaligned = 1'b0;
    case (i_func3)
      F3_B:  ;
      F3_H:  o_misaligned = i_addr[0];
      F3_W:  o_misaligned = |i_addr[1:0];
      F3_BU: o_illegal = i_is_store;
      F3_HU: begin
        o_illegal    = i_is_store;
        o_misaligned = i_addr[0];
      end
      default: o_illegal = 1'b1;
    endcase
  end

  assign o_out_of_range = {1'b0, i_addr} >= ADDR_LIMIT;

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: qualifies the request from EX/MEM, runs the
// Read/Write + busywait handshake with Data_Memory, stalls the pipeline while
// the access is in flight, and returns the load result with a valid strobe.
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int MEM_WORDS      = 1024,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [2:0]  Func3_in,
  input  logic [31:0] Address_in,
  input  logic [31:0] Store_data_in,
  output logic        Mem_Read,
  output logic        Mem_Write,
  output logic [31:0] Mem_Address,
  output logic [31:0] Mem_Write_data,
  output logic [2:0]  Mem_Func3,
  input  logic [31:0] Mem_Read_data,
  input  logic        Mem_busywait,
  output logic [31:0] Load_data,
  output logic        Load_valid,
  output logic        Stall,
  output logic        Misaligned,
  output logic        Access_fault,
  output logic        Timeout
);

  state_e      r_state, w_next_state;
  logic [7:0]  r_count;
  logic        r_is_read;
  logic        r_mem_read, r_mem_write;
  logic [31:0] r_addr, r_wdata, r_load_data;
  logic [2:0]  r_func3;
  logic        r_load_valid, r_misaligned, r_fault, r_timeout;

  logic w_req, w_illegal, w_misaligned, w_out_of_range;
  logic w_fault, w_good, w_done, w_timeout;

  mem_access_check #(
    .MEM_WORDS(MEM_WORDS)
  ) u_check (
    .i_is_store    (MemWrite_in),
    .i_func3       (Func3_in),
    .i_addr        (Address_in),
    .o_illegal     (w_illegal),
    .o_misaligned  (w_misaligned),
    .o_out_of_range(w_out_of_range)
  );

  // Fault beats misalignment; read and write together is always a fault.
  assign w_req   = MemRead_in ^ MemWrite_in;
  assign w_fault = (MemRead_in & MemWrite_in) | (w_req & (w_illegal | w_out_of_range));
  assign w_good  = w_req & ~w_illegal & ~w_out_of_range & ~w_misaligned;

  // The first WAIT cycle is ignored because the memory's busywait is registered
  // and cannot have risen yet.
  assign w_done    = (r_count != 8'd0) & ~Mem_busywait;
  assign w_timeout = ~w_done & (({1'b0, r_count} + 9'd1) >= 9'(TIMEOUT_CYCLES));

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state decode and pipeline stall
  always_comb begin
    w_next_state = r_state;
    Stall        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_good) begin
          Stall        = 1'b1;
          w_next_state = ST_REQ;
        end
      end
      ST_REQ: begin
        Stall        = 1'b1;
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        Stall = 1'b1;
        if (w_done || w_timeout) w_next_state = ST_RESP;
      end
      ST_RESP:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Request latch, memory handshake, WAIT counter, load capture and status pulses
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_count      <= '0;
      r_is_read    <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_func3      <= '0;
      r_load_data  <= '0;
      r_load_valid <= 1'b0;
      r_misaligned <= 1'b0;
      r_fault      <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values,
      // independent of statement order.
      r_load_valid <= 1'b0;
      r_timeout    <= 1'b0;
      r_misaligned <= (r_state == ST_IDLE) & w_req & w_misaligned & ~w_fault;
      r_fault      <= (r_state == ST_IDLE) & w_fault;
      case (r_state)
        ST_IDLE: begin
          if (w_good) begin
            r_addr      <= Address_in;
            r_wdata     <= Store_data_in;
            r_func3     <= Func3_in;
            r_is_read   <= MemRead_in;
            r_mem_read  <= MemRead_in;
            r_mem_write <= MemWrite_in;
          end
        end
        ST_REQ: r_count <= '0;
        ST_WAIT: begin
          r_count <= r_count + 8'd1;
          if (w_done || w_timeout) begin
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_load_valid <= r_is_read;
            r_timeout    <= ~w_done;
            if (r_is_read) r_load_data <= w_done ? Mem_Read_data : 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign Mem_Read       = r_mem_read;
  assign Mem_Write      = r_mem_write;
  assign Mem_Address    = r_addr;
  assign Mem_Write_data = r_wdata;
  assign Mem_Func3      = r_func3;
  assign Load_data      = r_load_data;
  assign Load_valid     = r_load_valid;
  assign Misaligned     = r_misaligned;
  assign Access_fault   = r_fault;
  assign Timeout        = r_timeout;

endmodule
